// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the multi-channel memory request arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int RR_FIXED = 0;
  localparam int RR_ROUND = 1;

  // (a + b) mod n, used for the round-robin search order and pointer advance.
  function automatic int unsigned wrap_add(input int unsigned a, input int unsigned b,
                                           input int unsigned n);
    return (a + b) % n;
  endfunction

endpackage

// File: rtl/arb_select.sv
// Combinational winner pick: lock owner first, then first requester found
// searching upward from the base index (0 in fixed mode, rr_ptr in RR mode).
module arb_select
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int RR_MODE = RR_FIXED,
  parameter int IDX_W   = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [IDX_W-1:0]  rr_ptr,
  input  logic              lock_valid,
  input  logic [IDX_W-1:0]  lock_owner,
  output logic [NUM_CH-1:0] win_oh,
  output logic [IDX_W-1:0]  win_idx,
  output logic              win_vld
);

  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] j;

  // Fixed priority is round-robin with the search anchored at channel 0.
  assign base = (RR_MODE == RR_ROUND) ? rr_ptr : '0;

  // Scan from the far end back toward base so the nearest requester is the last write.
  always_comb begin
    win_idx = '0;
    win_vld = 1'b0;
    win_oh  = '0;
    j       = '0;
    if (lock_valid && req[lock_owner]) begin
      win_idx = lock_owner;
      win_vld = 1'b1;
    end else begin
      for (int k = NUM_CH - 1; k >= 0; k--) begin
        j = IDX_W'(wrap_add(32'(base), 32'(k), NUM_CH));
        if (req[j]) begin
          win_idx = j;
          win_vld = 1'b1;
        end
      end
    end
    if (win_vld) win_oh[win_idx] = 1'b1;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Arbitrates NUM_CH masters onto a single-ported RAM with a busy handshake.
// One transaction in flight: IDLE selects, ISSUE pulses the RAM strobe,
// WAIT rides out ram_busy (with a watchdog), DONE retires and updates
// the lock owner and round-robin pointer.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int RR_MODE = RR_FIXED,
  parameter int TIMEOUT = 255
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic [NUM_CH-1:0]              req,
  input  logic [NUM_CH-1:0]              wen,
  input  logic [NUM_CH-1:0]              lock,
  input  logic [NUM_CH-1:0][ADDR_W-1:0]  addr,
  input  logic [NUM_CH-1:0][DATA_W-1:0]  wdata,
  output logic [NUM_CH-1:0]              ready,
  output logic [NUM_CH-1:0]              grant,
  output logic [DATA_W-1:0]              rdata,
  output logic                           err,
  output logic [ADDR_W-1:0]              ram_addr,
  output logic [DATA_W-1:0]              ram_wdata,
  output logic                           ram_wen,
  output logic                           ram_ren,
  input  logic [DATA_W-1:0]              ram_rdata,
  input  logic                           ram_busy
);

  localparam int IDX_W = $clog2(NUM_CH);
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_t        state;
  logic [IDX_W-1:0]  win_idx;
  logic [IDX_W-1:0]  rr_ptr;
  logic              lock_valid;
  logic [IDX_W-1:0]  lock_owner;
  logic [CNT_W-1:0]  cnt;

  logic [NUM_CH-1:0] sel_oh;
  logic [IDX_W-1:0]  sel_idx;
  logic              sel_vld;

  arb_select #(
    .NUM_CH  (NUM_CH),
    .RR_MODE (RR_MODE),
    .IDX_W   (IDX_W)
  ) u_sel (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .lock_valid (lock_valid),
    .lock_owner (lock_owner),
    .win_oh     (sel_oh),
    .win_idx    (sel_idx),
    .win_vld    (sel_vld)
  );

  // Transaction FSM; every output is registered and changes on state entry.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      win_idx    <= '0;
      rr_ptr     <= '0;
      lock_valid <= 1'b0;
      lock_owner <= '0;
      cnt        <= '0;
      ready      <= '0;
      grant      <= '0;
      rdata      <= '0;
      err        <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
      ram_wen    <= 1'b0;
      ram_ren    <= 1'b0;
    end else begin
      ready   <= '0;
      err     <= 1'b0;
      ram_wen <= 1'b0;
      ram_ren <= 1'b0;
      case (state)
        IDLE: begin
          // An owner that let go of req loses the lock before anyone is picked.
          if (lock_valid && !req[lock_owner]) lock_valid <= 1'b0;
          if (sel_vld) begin
            state     <= ISSUE;
            win_idx   <= sel_idx;
            grant     <= sel_oh;
            ram_addr  <= addr[sel_idx];
            ram_wdata <= wdata[sel_idx];
            ram_wen   <= wen[sel_idx];
            ram_ren   <= ~wen[sel_idx];
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (!ram_busy) begin
            rdata     <= ram_rdata;
            ready     <= grant;
            grant     <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            state     <= DONE;
          end else begin
            if (cnt != {CNT_W{1'b1}}) cnt <= cnt + 1'b1;
            // This busy cycle brings the count to TIMEOUT: give up on the RAM.
            if (cnt >= CNT_W'(TIMEOUT - 1)) begin
              rdata     <= '0;
              ready     <= grant;
              err       <= 1'b1;
              grant     <= '0;
              ram_addr  <= '0;
              ram_wdata <= '0;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (lock[win_idx] && req[win_idx]) begin
            lock_valid <= 1'b1;
            lock_owner <= win_idx;
          end else begin
            lock_valid <= 1'b0;
            if (RR_MODE == RR_ROUND) rr_ptr <= IDX_W'(wrap_add(32'(win_idx), 1, NUM_CH));
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Scoreboard bench: a fixed-priority and a round-robin instance share all
// inputs; expected transactions are queued per instance and a negedge
// monitor checks each RAM issue and each ready pulse against the queue head.
module tb_mem_req_arbiter;

  localparam int NCH = 3;
  localparam int TMO = 4;

  logic              clk;
  logic              nrst;
  logic [NCH-1:0]    req, wen, lock;
  logic [NCH-1:0][31:0] addr, wdata;
  logic [31:0]       ram_rdata;
  logic              ram_busy;

  logic [NCH-1:0] fp_ready, fp_grant, rr_ready, rr_grant;
  logic [31:0]    fp_rdata, rr_rdata, fp_ram_addr, rr_ram_addr, fp_ram_wdata, rr_ram_wdata;
  logic           fp_err, rr_err, fp_ram_wen, fp_ram_ren, rr_ram_wen, rr_ram_ren;

  mem_req_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT(TMO)) u_fp (
    .clk(clk), .nrst(nrst), .req(req), .wen(wen), .lock(lock), .addr(addr), .wdata(wdata),
    .ready(fp_ready), .grant(fp_grant), .rdata(fp_rdata), .err(fp_err),
    .ram_addr(fp_ram_addr), .ram_wdata(fp_ram_wdata), .ram_wen(fp_ram_wen), .ram_ren(fp_ram_ren),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy));

  mem_req_arbiter #(.NUM_CH(NCH), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT(TMO)) u_rr (
    .clk(clk), .nrst(nrst), .req(req), .wen(wen), .lock(lock), .addr(addr), .wdata(wdata),
    .ready(rr_ready), .grant(rr_grant), .rdata(rr_rdata), .err(rr_err),
    .ram_addr(rr_ram_addr), .ram_wdata(rr_ram_wdata), .ram_wen(rr_ram_wen), .ram_ren(rr_ram_ren),
    .ram_rdata(ram_rdata), .ram_busy(ram_busy));

  typedef struct {
    int          ch;
    bit          wr;
    logic [31:0] a;
    logic [31:0] rd;
    bit          e;
    int          lat;   // cycles from the issue cycle to the ready cycle
  } exp_t;

  exp_t q_fp[$];
  exp_t q_rr[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   issue_cyc[2];
  int   busy_len = 0;
  int   busy_left = 0;
  logic stuck = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: busy for busy_len WAIT cycles after each issue, or forever when stuck.
  always @(posedge clk) begin
    #1;
    if (fp_ram_wen || fp_ram_ren) busy_left <= busy_len + 1;
    else if (busy_left > 0)       busy_left <= busy_left - 1;
  end
  assign ram_busy = stuck || (busy_left != 0);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input int id, input int ch, input bit wr, input logic [31:0] rd,
                      input bit e, input int lat);
    exp_t x;
    x.ch = ch; x.wr = wr; x.a = addr[ch]; x.rd = rd; x.e = e; x.lat = lat;
    if (id == 0) q_fp.push_back(x); else q_rr.push_back(x);
  endtask

  task automatic mon(input int id, input logic [2:0] rdy, input logic [2:0] gnt,
                     input logic [31:0] rd, input logic e, input logic [31:0] ra,
                     input logic [31:0] rwd, input logic rw, input logic rr);
    exp_t  x;
    bit    have;
    string p;
    p    = (id == 0) ? "fp" : "rr";
    have = 0;
    if (id == 0 && q_fp.size() > 0) begin x = q_fp[0]; have = 1; end
    if (id == 1 && q_rr.size() > 0) begin x = q_rr[0]; have = 1; end
    if (rw || rr) begin
      if (!have) chk({p, ".spurious_issue"}, 32'(rw | rr), 0);
      else begin
        chk({p, ".ram_addr"}, ra, x.a);
        chk({p, ".ram_wen"}, 32'(rw), 32'(x.wr));
        chk({p, ".ram_ren"}, 32'(rr), 32'(!x.wr));
        chk({p, ".grant"}, 32'(gnt), 32'(3'b001 << x.ch));
        if (x.wr) chk({p, ".ram_wdata"}, rwd, wdata[x.ch]);
        issue_cyc[id] = cyc;
      end
    end
    if (rdy != 0) begin
      if (!have) chk({p, ".spurious_ready"}, 32'(rdy), 0);
      else begin
        chk({p, ".ready"}, 32'(rdy), 32'(3'b001 << x.ch));
        chk({p, ".rdata"}, rd, x.rd);
        chk({p, ".err"}, 32'(e), 32'(x.e));
        chk({p, ".grant_done"}, 32'(gnt), 0);
        chk({p, ".latency"}, 32'(cyc - issue_cyc[id]), 32'(x.lat));
        if (id == 0) void'(q_fp.pop_front()); else void'(q_rr.pop_front());
      end
    end else begin
      chk({p, ".err_alone"}, 32'(e), 0);
    end
  endtask

  always @(negedge clk) begin
    mon(0, fp_ready, fp_grant, fp_rdata, fp_err, fp_ram_addr, fp_ram_wdata, fp_ram_wen, fp_ram_ren);
    mon(1, rr_ready, rr_grant, rr_rdata, rr_err, rr_ram_addr, rr_ram_wdata, rr_ram_wen, rr_ram_ren);
  end

  task automatic chk_quiet(input string tag);
    chk({tag, ".grant"}, 32'(fp_grant | rr_grant), 0);
    chk({tag, ".ready"}, 32'(fp_ready | rr_ready), 0);
    chk({tag, ".err"}, 32'(fp_err | rr_err), 0);
    chk({tag, ".ram_ctl"}, 32'({fp_ram_wen, fp_ram_ren, rr_ram_wen, rr_ram_ren}), 0);
    chk({tag, ".ram_addr"}, fp_ram_addr | rr_ram_addr, 0);
    chk({tag, ".ram_wdata"}, fp_ram_wdata | rr_ram_wdata, 0);
  endtask

  task automatic do_reset();
    nrst = 1'b0; req = '0; lock = '0;
    @(negedge clk);
    chk_quiet("rst");
    chk("rst.rdata", fp_rdata | rr_rdata, 0);
    @(negedge clk);
    nrst = 1'b1;
  endtask

  task automatic wait_ready(input int n, input string tag);
    int got = 0;
    for (int c = 0; c < 200 && got < n; c++) begin
      @(negedge clk);
      if (fp_ready != 0) got++;
    end
    chk({tag, ".ready_count"}, 32'(got), 32'(n));
  endtask

  task automatic wait_grant(input logic [2:0] g, input string tag);
    int c = 0;
    while (fp_grant != g && c < 50) begin
      @(negedge clk);
      c++;
    end
    chk({tag, ".grant_seen"}, 32'(fp_grant), 32'(g));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b0; req = '0; wen = '0; lock = '0; ram_rdata = '0;
    addr  = {32'h0000_0200, 32'h0000_0040, 32'h0000_0100};
    wdata = {32'hC2C2_0002, 32'hB1B1_0001, 32'hA0A0_0000};
    do_reset();

    // Idle with busy high: nothing may reach the RAM.
    stuck = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_quiet("idle");
    end
    stuck = 1'b0;

    // Single read on channel 1, ready three cycles after req.
    ram_rdata = 32'hDEAD_BEEF; busy_len = 0; wen = '0;
    push(0, 1, 0, 32'hDEAD_BEEF, 0, 2);
    push(1, 1, 0, 32'hDEAD_BEEF, 0, 2);
    req = 3'b010;
    repeat (3) @(negedge clk);
    chk("rd1.ready_t3", 32'(fp_ready), 32'(3'b010));
    chk("rd1.rdata", fp_rdata, 32'hDEAD_BEEF);
    req = '0;

    // All channels requesting, busy two cycles: fixed always 0, RR rotates.
    do_reset();
    busy_len = 2; ram_rdata = 32'h1234_5678; wen = '0;
    for (int i = 0; i < 6; i++) begin
      push(0, 0, 0, 32'h1234_5678, 0, 4);
      push(1, i % 3, 0, 32'h1234_5678, 0, 4);
    end
    req = 3'b111;
    wait_ready(6, "prio");
    req = '0;

    // Locked burst of four writes from channel 2 with channel 0 waiting.
    do_reset();
    busy_len = 1; ram_rdata = 32'h5A5A_0003; wen = 3'b100;
    for (int i = 0; i < 4; i++) begin
      push(0, 2, 1, 32'h5A5A_0003, 0, 3);
      push(1, 2, 1, 32'h5A5A_0003, 0, 3);
    end
    push(0, 0, 0, 32'h5A5A_0003, 0, 3);
    push(1, 0, 0, 32'h5A5A_0003, 0, 3);
    req = 3'b100; lock = 3'b100;
    wait_grant(3'b100, "lock");
    req = 3'b101;
    wait_ready(4, "lock.burst");
    req = 3'b001; lock = '0;
    wait_ready(1, "lock.ch0");
    req = '0;

    // Stuck RAM: timeout after TMO WAIT cycles, then a normal read.
    do_reset();
    stuck = 1'b1; busy_len = 0; wen = 3'b001; ram_rdata = 32'h7777_7777;
    push(0, 0, 1, 32'h0, 1, TMO + 1);
    push(1, 0, 1, 32'h0, 1, TMO + 1);
    req = 3'b001;
    wait_ready(1, "tmo");
    req = '0; stuck = 1'b0; ram_rdata = 32'hCAFE_F00D; wen = '0;
    push(0, 2, 0, 32'hCAFE_F00D, 0, 2);
    push(1, 2, 0, 32'hCAFE_F00D, 0, 2);
    req = 3'b100;
    wait_ready(1, "tmo.next");
    req = '0;

    // Reset while waiting on a busy RAM; RR pointer must return to 0.
    do_reset();
    busy_len = 0; ram_rdata = 32'h1111_2222; wen = '0;
    push(0, 0, 0, 32'h1111_2222, 0, 2);
    push(1, 0, 0, 32'h1111_2222, 0, 2);
    req = 3'b001;
    wait_ready(1, "pre");
    req = '0;
    stuck = 1'b1;
    push(0, 1, 0, 32'h1111_2222, 0, 2);
    push(1, 1, 0, 32'h1111_2222, 0, 2);
    req = 3'b010;
    wait_grant(3'b010, "rmw");
    @(negedge clk);
    @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    chk_quiet("rmw");
    q_fp.delete();
    q_rr.delete();
    req = '0; stuck = 1'b0;
    @(negedge clk);
    chk("rmw.ready_hold", 32'(fp_ready | rr_ready), 0);
    @(negedge clk);
    nrst = 1'b1;
    push(0, 0, 0, 32'h1111_2222, 0, 2);
    push(1, 0, 0, 32'h1111_2222, 0, 2);
    req = 3'b111;
    wait_ready(1, "post");
    req = '0;

    repeat (4) @(negedge clk);
    chk("fp.queue_empty", 32'(q_fp.size()), 0);
    chk("rr.queue_empty", 32'(q_rr.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
Name: mem_req_arbiter

Overview:
- Parametrised successor to the single-requester memory request path.
- Arbitrates NUM_CH masters onto the single-ported ru_ram-style RAM, which has a busy handshake. Typical masters: instruction fetch, data load/store, FPGA calculator loader.
- Supports fixed-priority or round-robin selection, a per-channel bus lock for multi-word bursts, and a per-transaction watchdog that flags a hung RAM.

Parameters:
- NUM_CH, 3, number of requesting channels (2..8); channel 0 has highest fixed priority.
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin.
- TIMEOUT, 255, maximum cycles spent waiting on ram_busy before abort; must be at least 1.

Ports:
- clk  in  1  system clock
- nrst  in  1  asynchronous active-low reset
- req  in  NUM_CH  per-channel request; held high until that channel's ready pulse
- wen  in  NUM_CH  per-channel write (1) / read (0)
- lock  in  NUM_CH  channel holds the bus after completion while lock and req remain high
- addr  in  NUM_CH x ADDR_W  per-channel address (packed)
- wdata  in  NUM_CH x DATA_W  per-channel store data (packed)
- ready  out  NUM_CH  one-cycle completion pulse to the winning channel
- grant  out  NUM_CH  one-hot; current bus owner, valid from issue through completion
- rdata  out  DATA_W  read data; valid in the cycle ready is high
- err  out  1  one-cycle pulse alongside ready when a transaction timed out
- ram_addr  out  ADDR_W  to RAM
- ram_wdata  out  DATA_W  to RAM
- ram_wen  out  1  to RAM, asserted for the issue cycle only
- ram_ren  out  1  to RAM, asserted for the issue cycle only
- ram_rdata  in  DATA_W  from RAM
- ram_busy  in  1  RAM is processing

Behaviour:
- Reset:
  - Applied asynchronously on nrst low.
  - Outputs: state IDLE; grant, ready and err = 0; rdata = 0; ram_* = 0.
  - RR pointer = 0; lock owner cleared; timeout counter = 0.
- State IDLE:
  - If any req is high, select winner W and register W, its addr, wdata and wen; go to ISSUE.
  - Otherwise stay in IDLE.
  - The selection is registered, so a request raised in cycle t is issued in cycle t+1.
- Winner selection, in priority order:
  - Locked owner: if the lock owner still has req high, it wins.
  - Fixed priority (RR_MODE = 0): lowest index with req high wins.
  - Round-robin (RR_MODE = 1): first index with req high, searching from rr_ptr upward and wrapping modulo NUM_CH.
- State ISSUE (exactly 1 cycle):
  - Drive ram_addr and ram_wdata from the registered winner.
  - Assert ram_wen = wen[W] or ram_ren = !wen[W]; set grant[W].
  - Go to WAIT. Clear the timeout counter.
- State WAIT:
  - ram_addr and ram_wdata are held; ram_wen and ram_ren are 0; grant is held.
  - Completion condition: ram_busy low in any WAIT cycle, including the first. On completion:
    - Capture ram_rdata into rdata.
    - Pulse ready[W] for one cycle.
    - Go to DONE.
  - While ram_busy is high, increment the counter. When the counter reaches TIMEOUT:
    - Pulse ready[W] and err together; rdata = 0.
    - Go to DONE.
- State DONE (1 cycle):
  - grant is cleared.
  - In RR mode, update rr_ptr = (W+1) mod NUM_CH. The pointer is not updated while a lock is held.
  - If lock[W] and req[W] are both high, record W as lock owner; otherwise clear the lock owner.
  - Go to IDLE.
  - Minimum transaction latency, req rising to ready: 3 cycles (IDLE select, ISSUE, WAIT with busy low).
- Boundary cases:
  - Requester drops req mid-transaction: the transaction still completes; the ready pulse is ignored by the requester.
  - A master that drops req must not re-raise it in the same cycle that ready arrives.
  - Lock owner drops req: the lock clears at the next IDLE and normal arbitration resumes.
  - All req low: remain in IDLE; ram_* stay 0.
  - ram_busy high while IDLE: ignored; issue still proceeds.
  - A new request arriving during WAIT is held off until IDLE.
  - nrst low mid-WAIT: immediate return to the reset state; no ready or err pulse is produced.
  - The timeout counter is sized to $clog2(TIMEOUT+1) bits and saturates; it never wraps.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum (IDLE, ISSUE, WAIT, DONE).
  - Localparam constants for RR_MODE values.
- Sub-module arb_select: combinational winner pick.
  - Inputs: req, rr_ptr, lock_valid, lock_owner, RR_MODE.
  - Outputs: one-hot winner and its index.
  - Verified standalone.

Test Plan:
- Single read: req[1]=1, wen=0, addr=0x40; ram_busy low; ram_rdata=0xDEADBEEF → ram_ren pulses 1 cycle with ram_addr=0x40; ready[1] is high 3 cycles after req with rdata=0xDEADBEEF.
- Fixed priority: RR_MODE=0, req=3'b111 held, busy held 2 cycles per transaction → channel 0 is served every time; channels 1 and 2 starve; grant=3'b001 each transaction.
- Round-robin: RR_MODE=1, req=3'b111 held → completion order is 0, 1, 2, 0, 1, 2; each ready is a single-cycle pulse.
- Lock burst: RR_MODE=1, channel 2 with lock=1 and req held for 4 writes while req[0]=1 → 4 consecutive ram_wen to channel 2; channel 0 is served only after lock[2] drops.
- Timeout: TIMEOUT=4, ram_busy stuck high → ready and err pulse together after 4 WAIT cycles; rdata=0; the next request issues normally.
- Reset mid-WAIT: nrst low during WAIT with busy high → grant, ram_* and ready are all 0 immediately; state IDLE; rr_ptr=0 after release.
